// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I core constants and the fetch FSM state type.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [1:0] {REQ, FULL, DRAIN} fetch_state_t;
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~32'h3;
   endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; ports: clk, reset, load_i/hold_i/flush_i controls, instr_i/pc_i data in, valid_o/instr_o/pc_o toward decode.
module if_id_reg
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic            hold_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o
);
   logic            valid_q;
   logic [XLEN-1:0] instr_q, pc_q;
   // Flush beats hold; with neither load nor hold the register empties to a bubble.
   always_ff @(posedge clk) begin
      if (reset || flush_i || (!load_i && !hold_i)) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end
   end
   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC, skid buffer and redirect drain; ports: clk, reset, stall_i, redirect_i/redirect_pc_i, imem req/addr/ack/rdata, id valid/instr/pc.
module fetch_stage
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            id_valid_o,
   output logic [XLEN-1:0] id_instr_o,
   output logic [XLEN-1:0] id_pc_o
);
   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d, drain_q, drain_d;
   logic [XLEN-1:0] target, id_instr, id_pc;
   logic            id_load;
   assign target = word_align(redirect_pc_i);
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= REQ;
         pc_q         <= RESET_PC;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         drain_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         drain_q      <= drain_d;
      end
   end
   always_comb begin
      state_d = REQ;
      case (state_q)
         REQ:     state_d = redirect_i ? (imem_ack_i ? REQ : DRAIN) : (imem_ack_i && stall_i ? FULL : REQ);
         FULL:    state_d = redirect_i || !stall_i ? REQ : FULL;
         DRAIN:   state_d = imem_ack_i ? REQ : DRAIN;
         default: state_d = REQ;
      endcase
   end
   always_comb begin
      pc_d = pc_q;
      case (state_q)
         REQ:     pc_d = imem_ack_i ? (redirect_i ? target : pc_q + 32'd4) : pc_q;
         FULL:    pc_d = redirect_i ? target : pc_q;
         DRAIN:   pc_d = imem_ack_i ? (redirect_i ? target : drain_q) : pc_q;
         default: pc_d = pc_q;
      endcase
      // A redirect with the access still outstanding must wait for the ack before retargeting.
      drain_d = redirect_i && (state_q == DRAIN || (state_q == REQ && !imem_ack_i)) ? target : drain_q;
      skid_instr_d = state_q == REQ && imem_ack_i && !redirect_i && stall_i ? imem_rdata_i : skid_instr_q;
      skid_pc_d    = state_q == REQ && imem_ack_i && !redirect_i && stall_i ? pc_q : skid_pc_q;
      id_load  = !redirect_i && !stall_i && ((state_q == REQ && imem_ack_i) || state_q == FULL);
      id_instr = state_q == FULL ? skid_instr_q : imem_rdata_i;
      id_pc    = state_q == FULL ? skid_pc_q : pc_q;
   end
   assign imem_req_o  = !reset && state_q != FULL;
   assign imem_addr_o = pc_q;
   if_id_reg u_if_id (
      .clk     (clk),
      .reset   (reset),
      .load_i  (id_load),
      .hold_i  (stall_i),
      .flush_i (redirect_i),
      .instr_i (id_instr),
      .pc_i    (id_pc),
      .valid_o (id_valid_o),
      .instr_o (id_instr_o),
      .pc_o    (id_pc_o)
   );
endmodule
